// File: rtl/add_4_if.sv
// add_4_if: operand/result bundle for the registered adder slice.
//   in_valid, a, b, cin   : operand side, driven by the master
//   sum, cout, ovf, zero  : registered result and status flags, driven by the slave
//   out_valid             : result registers were loaded at the last edge
// Modports:
//   master : ALU/datapath side (drives the operands, observes the result)
//   slave  : the adder itself
interface add_4_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  sum, cout, ovf, zero, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output sum, cout, ovf, zero, out_valid
    );
endinterface

// File: rtl/add_4.sv
// add_4: registered WIDTH-bit ripple-carry adder slice for the ALU datapath.
// Computes {cout, sum} = a + b + cin through a chain of full-adder cells and
// captures the result plus signed-overflow and zero flags one clock later.
// Ports:
//   clk    : system clock, rising edge active
//   rst_n  : asynchronous active-low reset, clears all result registers
//   bus    : add_4_if slave modport
//              in_valid/a/b/cin in, sum/cout/ovf/zero/out_valid out
// While in_valid is low the result registers keep their contents (only
// out_valid drops), so X on the operand lines cannot reach the outputs.
module add_4 #(
    parameter int WIDTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    add_4_if.slave  bus
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             ovf_next;
    logic             zero_next;

    assign carry[0] = bus.cin;

    // One full-adder cell per bit, rippling LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic prop;
        assign prop         = bus.a[i] ^ bus.b[i];
        assign sum_next[i]  = prop ^ carry[i];
        assign carry[i + 1] = (bus.a[i] & bus.b[i]) | (carry[i] & prop);
    end

    assign cout_next = carry[WIDTH];

    // Two's complement overflow: like-signed operands giving a result of the
    // opposite sign.
    assign ovf_next  = (bus.a[MSB] == bus.b[MSB]) && (sum_next[MSB] != bus.a[MSB]);

    // Looks at sum only; a wrap to zero with cout set still reports zero.
    assign zero_next = (sum_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.zero      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum  <= sum_next;
                bus.cout <= cout_next;
                bus.ovf  <= ovf_next;
                bus.zero <= zero_next;
            end
        end
    end

endmodule

// File: tb/tb_add_4.sv
module tb_add_4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [3:0] m_sum;
    logic       m_cout;
    logic       m_ovf;
    logic       m_zero;
    logic       m_valid;

    add_4_if #(.WIDTH(4)) bus ();

    add_4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sum   = 4'd0;
        m_cout  = 1'b0;
        m_ovf   = 1'b0;
        m_zero  = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_sum"},   {28'd0, bus.sum},       {28'd0, m_sum});
        check({tag, "_cout"},  {31'd0, bus.cout},      {31'd0, m_cout});
        check({tag, "_ovf"},   {31'd0, bus.ovf},       {31'd0, m_ovf});
        check({tag, "_zero"},  {31'd0, bus.zero},      {31'd0, m_zero});
        check({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, m_valid});
    endtask

    // Called at a falling edge: drive operands, let one rising edge pass,
    // then compare at the next falling edge.
    task automatic step(input logic v, input logic [3:0] ai, input logic [3:0] bi,
                        input logic ci, input string tag);
        int full;
        int sa;
        int sb;
        int ss;
        bus.in_valid = v;
        bus.a        = ai;
        bus.b        = bi;
        bus.cin      = ci;
        if (v === 1'b1) begin
            full   = int'(ai) + int'(bi) + int'(ci);
            m_sum  = full[3:0];
            m_cout = full[4];
            m_zero = (full % 16) == 0;
            sa     = ai[3] ? int'(ai) - 16 : int'(ai);
            sb     = bi[3] ? int'(bi) - 16 : int'(bi);
            ss     = sa + sb + int'(ci);
            m_ovf  = (ss > 7) || (ss < -8);
        end
        m_valid = (v === 1'b1);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [3:0] ri;
        logic [3:0] rj;
        logic [3:0] rb;
        logic       rc;
        logic       rv;

        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 4'd0;
        bus.b        = 4'd0;
        bus.cin      = 1'b0;
        model_reset();

        #2;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Complementary sweep: always 15, one result per clock.
        for (int i = 0; i < 16; i++) begin
            ri = 4'(i);
            rj = 4'(15 - i);
            step(1'b1, ri, rj, 1'b0, "comp");
            check("comp_sum15", {28'd0, bus.sum}, 32'd15);
            check("comp_zero0", {31'd0, bus.zero}, 32'd0);
        end

        // Doubling sweep with carry-in.
        for (int i = 0; i < 16; i++) begin
            ri = 4'(i);
            step(1'b1, ri, ri, 1'b1, "dbl");
            if (i == 7) begin
                check("dbl7_sum",   {28'd0, bus.sum},  32'd15);
                check("dbl7_cout",  {31'd0, bus.cout}, 32'd0);
            end
            if (i == 8) begin
                check("dbl8_sum",   {28'd0, bus.sum},  32'd1);
                check("dbl8_cout",  {31'd0, bus.cout}, 32'd1);
            end
            if (i == 15) begin
                check("dbl15_sum",  {28'd0, bus.sum},  32'd15);
                check("dbl15_cout", {31'd0, bus.cout}, 32'd1);
            end
        end

        // Flags.
        step(1'b1, 4'd8, 4'd8, 1'b0, "f88");
        check("f88_sum",  {28'd0, bus.sum},  32'd0);
        check("f88_cout", {31'd0, bus.cout}, 32'd1);
        check("f88_zero", {31'd0, bus.zero}, 32'd1);
        check("f88_ovf",  {31'd0, bus.ovf},  32'd1);
        step(1'b1, 4'd7, 4'd1, 1'b0, "f71");
        check("f71_sum",  {28'd0, bus.sum},  32'd8);
        check("f71_cout", {31'd0, bus.cout}, 32'd0);
        check("f71_ovf",  {31'd0, bus.ovf},  32'd1);
        step(1'b1, 4'd15, 4'd1, 1'b0, "f151");
        check("f151_sum",  {28'd0, bus.sum},  32'd0);
        check("f151_cout", {31'd0, bus.cout}, 32'd1);
        check("f151_ovf",  {31'd0, bus.ovf},  32'd0);
        check("f151_zero", {31'd0, bus.zero}, 32'd1);

        // Hold: idle cycles keep the last result, even with X operands.
        step(1'b1, 4'd3, 4'd4, 1'b0, "h34");
        step(1'b0, 4'd15, 4'd15, 1'b1, "hold");
        check("hold_sum",   {28'd0, bus.sum},       32'd7);
        check("hold_cout",  {31'd0, bus.cout},      32'd0);
        check("hold_valid", {31'd0, bus.out_valid}, 32'd0);
        step(1'b0, 4'bxxxx, 4'bxxxx, 1'bx, "holdx");
        check("holdx_sum", {28'd0, bus.sum}, 32'd7);

        // Asynchronous reset mid-cycle with a result pending on the inputs.
        step(1'b1, 4'd9, 4'd9, 1'b0, "pre_rst");
        bus.in_valid = 1'b1;
        bus.a        = 4'd5;
        bus.b        = 4'd3;
        bus.cin      = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_now");
        repeat (2) begin
            @(negedge clk);
            check_all("rst_hold");
        end
        rst_n = 1'b1;
        step(1'b1, 4'd5, 4'd3, 1'b0, "rel");
        check("rel_sum",  {28'd0, bus.sum},  32'd8);
        check("rel_cout", {31'd0, bus.cout}, 32'd0);
        check("rel_ovf",  {31'd0, bus.ovf},  32'd1);

        // Random operands with random idle gaps.
        for (int k = 0; k < 512; k++) begin
            ri = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            step(rv, ri, rb, rc, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/add_4.md
Name: add_4

Overview:
Registered 4-bit binary adder with carry-in and carry-out, used as the basic arithmetic slice of the ALU datapath. Computes a + b + cin through a ripple-carry chain of full-adder cells. Result and status flags are captured in output registers on the rising clock edge. Asynchronous active-low reset clears all outputs.

Parameters:
- WIDTH, 4, operand/sum width in bits. Only 4 is required to be verified; the RTL must stay correct for any WIDTH >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a/b/cin are valid this cycle
- a  input  WIDTH  operand A, unsigned (or two's complement for the ovf flag)
- b  input  WIDTH  operand B
- cin  input  1  carry in
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH
- cout  output  1  registered carry out of the MSB
- ovf  output  1  registered signed overflow
- zero  output  1  registered flag, 1 when sum == 0
- out_valid  output  1  sum/cout/ovf/zero hold a new result

Behaviour:
- Datapath: WIDTH full-adder cells chained LSB to MSB.
  - Cell i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)).
  - c_0 = cin; the raw carry-out is c_WIDTH.
- Full result is WIDTH+1 bits: {cout, sum} = a + b + cin. The maximum is 2*(2^WIDTH - 1) + 1, which always fits, so there is no loss beyond cout.
- ovf = (a[MSB] == b[MSB]) && (sum_next[MSB] != a[MSB]), computed from the combinational sum.
- zero = (sum_next == 0). It depends only on sum, not on cout; 8+8+0 gives zero=1, cout=1.
- Latency: exactly 1 clock.
  - When in_valid=1 at edge N, sum/cout/ovf/zero show that result after edge N.
  - out_valid=1 after edge N.
- When in_valid=0 at an edge:
  - sum/cout/ovf/zero hold their previous values.
  - out_valid goes to 0 after that edge.
- Back-to-back: in_valid held high loads a new result every cycle, giving one result per clock with no bubbles.
- Reset:
  - On rst_n low, asynchronously and immediately: sum=0, cout=0, ovf=0, zero=0, out_valid=0.
  - Outputs stay there while rst_n=0, regardless of clk or inputs.
- Reset deassertion is sampled synchronously: the first capture happens at the first rising edge with rst_n=1.
- Reset mid-operation: any pending result is discarded, and the capture at the next edge after release uses the inputs present then.
- Wrap-around: results of 2^WIDTH or more set cout=1, and sum keeps the low WIDTH bits.
- No X propagation: when in_valid=0, outputs are unaffected even if a, b or cin are X.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with a=5, b=3, in_valid=1 -> sum=0, cout=0, zero=0, ovf=0, out_valid=0 immediately; hold for 2 cycles, then release -> next edge gives sum=8, cout=0, ovf=1.
- Complementary sweep, cin=0: for i=0..15 drive a=i, b=15-i, in_valid=1 -> every result sum=15, cout=0, zero=0, one result per cycle, 1-cycle latency.
- Doubling sweep, cin=1: for i=0..15 drive a=b=i -> sum=(2i+1) mod 16, cout=1 iff i>=8. Checkpoints:
  - i=7 -> sum=15, cout=0
  - i=8 -> sum=1, cout=1
  - i=15 -> sum=15, cout=1
- Flags:
  - a=8, b=8, cin=0 -> sum=0, cout=1, zero=1, ovf=1
  - a=7, b=1, cin=0 -> sum=8, cout=0, ovf=1
  - a=15, b=1, cin=0 -> sum=0, cout=1, ovf=0, zero=1
- Hold behaviour: after a=3, b=4 (sum=7), drive in_valid=0 with a=15, b=15, cin=1 -> sum stays 7, cout stays 0, out_valid=0.
- Exhaustive random: 512 random {a, b, cin} with random in_valid gaps -> each output equals the reference {cout, sum} = a+b+cin one cycle later; ovf and zero match their formulas.
